// File: rtl/video_rx_pkg.sv
// Shared types and widths for the video stream receiver.
package video_rx_pkg;

    // Receiver framing state: hunting for start-of-frame, or inside a frame.
    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } rx_state_t;

    localparam int unsigned COORD_W     = 11;
    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned GAP_CNT_W   = 16;

endpackage

// File: rtl/video_xy_counter.sv
// Column/row position tracker for the video receiver.
// Priority of controls: clear > restart > line_close > inc.
module video_xy_counter
    import video_rx_pkg::*;
#(
    parameter int unsigned width  = 10,
    parameter int unsigned height = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,      // back to (0,0), frame finished
    input  logic               restart,    // SOF pixel consumed at (0,0); next is (1,0)
    input  logic               line_close, // line ended: x=0, y+1
    input  logic               inc,        // ordinary pixel: x+1
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last_pix,
    output logic               last_line
);

    localparam logic [COORD_W-1:0] XLast = COORD_W'(width - 1);
    localparam logic [COORD_W-1:0] YLast = COORD_W'(height - 1);

    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;

    // Position update, held whenever no control is asserted (tvalid gaps).
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clear) begin
            x_q <= '0;
            y_q <= '0;
        end else if (restart) begin
            x_q <= COORD_W'(1);
            y_q <= '0;
        end else if (line_close) begin
            x_q <= '0;
            y_q <= y_q + COORD_W'(1);
        end else if (inc) begin
            x_q <= x_q + COORD_W'(1);
        end
    end

    // Position flags for the FSM.
    always_comb begin
        x         = x_q;
        y         = y_q;
        last_pix  = (x_q == XLast);
        last_line = (y_q == YLast);
    end

endmodule

// File: rtl/video_stream_rx.sv
// AXI4-Stream video sink: recovers frame/line timing, tags pixels with (x,y)
// and flags protocol errors. No backpressure; tvalid gaps freeze everything.
// Optional macro VIDEO_RX_GAP_STAT_EN adds gap_cnt: tvalid-low cycles between
// the SOF beat and the final beat of the last completed frame.
module video_stream_rx
    import video_rx_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned width  = 10,
    parameter int unsigned height = 10
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [N-1:0]           s_video_tdata,
    input  logic                   s_video_tvalid,
    input  logic                   s_video_tlast,
    input  logic                   s_video_tuser,
    output logic [N-1:0]           pix_data,
    output logic                   pix_valid,
    output logic [COORD_W-1:0]     pix_x,
    output logic [COORD_W-1:0]     pix_y,
    output logic                   frame_done,
    output logic                   err_early_eol,
    output logic                   err_late_eol,
    output logic                   err_sof_mid,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef VIDEO_RX_GAP_STAT_EN
    ,
    output logic [GAP_CNT_W-1:0]   gap_cnt
`endif
);

    rx_state_t          state_q;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               last_pix;
    logic               last_line;

    logic beat_sof;   // any beat carrying tuser (restart wins over tlast)
    logic beat_act;   // ordinary in-frame beat
    logic line_end;
    logic frame_end;
    logic ctr_clear;
    logic ctr_restart;
    logic ctr_close;
    logic ctr_inc;

    // Beat classification and counter control.
    always_comb begin
        beat_sof    = s_video_tvalid & s_video_tuser;
        beat_act    = s_video_tvalid & ~s_video_tuser & (state_q == ACTIVE);
        line_end    = beat_act & (s_video_tlast | last_pix);
        frame_end   = line_end & last_line;
        ctr_clear   = frame_end;
        ctr_restart = beat_sof;
        ctr_close   = line_end & ~last_line;
        ctr_inc     = beat_act & ~line_end;
    end

    video_xy_counter #(
        .width  (width),
        .height (height)
    ) u_xy (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .clear      (ctr_clear),
        .restart    (ctr_restart),
        .line_close (ctr_close),
        .inc        (ctr_inc),
        .x          (cur_x),
        .y          (cur_y),
        .last_pix   (last_pix),
        .last_line  (last_line)
    );

    // Framing FSM with registered pixel, strobe and error outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= WAIT_SOF;
            pix_data      <= '0;
            pix_valid     <= 1'b0;
            pix_x         <= '0;
            pix_y         <= '0;
            frame_done    <= 1'b0;
            err_early_eol <= 1'b0;
            err_late_eol  <= 1'b0;
            err_sof_mid   <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            pix_valid     <= 1'b0;
            frame_done    <= 1'b0;
            err_early_eol <= 1'b0;
            err_late_eol  <= 1'b0;
            err_sof_mid   <= 1'b0;
            if (beat_sof) begin
                pix_valid   <= 1'b1;
                pix_data    <= s_video_tdata;
                pix_x       <= '0;
                pix_y       <= '0;
                err_sof_mid <= (state_q == ACTIVE);
                state_q     <= ACTIVE;
            end else if (beat_act) begin
                pix_valid     <= 1'b1;
                pix_data      <= s_video_tdata;
                pix_x         <= cur_x;
                pix_y         <= cur_y;
                err_early_eol <= s_video_tlast & ~last_pix;
                err_late_eol  <= last_pix & ~s_video_tlast;
                if (frame_end) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + FRAME_CNT_W'(1);
                    state_q    <= WAIT_SOF;
                end
            end
        end
    end

`ifdef VIDEO_RX_GAP_STAT_EN
    logic [GAP_CNT_W-1:0] gap_acc_q;

    // Saturating count of idle cycles inside a frame, published at frame end.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gap_acc_q <= '0;
            gap_cnt   <= '0;
        end else begin
            if (beat_sof) begin
                gap_acc_q <= '0;
            end else if ((state_q == ACTIVE) && !s_video_tvalid && (gap_acc_q != '1)) begin
                gap_acc_q <= gap_acc_q + GAP_CNT_W'(1);
            end
            if (frame_end) begin
                gap_cnt <= gap_acc_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_video_stream_rx.sv
// Directed bench for video_stream_rx (width=10, height=10).
module tb_video_stream_rx;
    import video_rx_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  s_video_tdata;
    logic        s_video_tvalid;
    logic        s_video_tlast;
    logic        s_video_tuser;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        frame_done;
    logic        err_early_eol;
    logic        err_late_eol;
    logic        err_sof_mid;
    logic [15:0] frame_cnt;
`ifdef VIDEO_RX_GAP_STAT_EN
    logic [15:0] gap_cnt;
`endif

    always #5 sys_clk = ~sys_clk;

    video_stream_rx #(
        .N      (8),
        .width  (10),
        .height (10)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .s_video_tdata  (s_video_tdata),
        .s_video_tvalid (s_video_tvalid),
        .s_video_tlast  (s_video_tlast),
        .s_video_tuser  (s_video_tuser),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .frame_done     (frame_done),
        .err_early_eol  (err_early_eol),
        .err_late_eol   (err_late_eol),
        .err_sof_mid    (err_sof_mid),
        .frame_cnt      (frame_cnt)
`ifdef VIDEO_RX_GAP_STAT_EN
        ,
        .gap_cnt        (gap_cnt)
`endif
    );

    typedef struct {
        logic [7:0]  d;
        logic [10:0] x;
        logic [10:0] y;
        logic        fd;
        logic        ee;
        logic        el;
        logic        sm;
    } rec_t;

    rec_t q[$];
    int   stray  = 0;
    int   checks = 0;
    int   passes = 0;

    // Capture every strobed pixel; count pulses that appear without a strobe.
    always @(negedge sys_clk) begin
        if (pix_valid === 1'b1) begin
            q.push_back('{pix_data, pix_x, pix_y, frame_done, err_early_eol, err_late_eol,
                          err_sof_mid});
        end else if ((frame_done | err_early_eol | err_late_eol | err_sof_mid) === 1'b1) begin
            stray++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic beat(input logic [7:0] d, input logic u, input logic l);
        s_video_tdata  = d;
        s_video_tvalid = 1'b1;
        s_video_tuser  = u;
        s_video_tlast  = l;
        @(posedge sys_clk);
        #1;
        s_video_tvalid = 1'b0;
        s_video_tuser  = 1'b0;
        s_video_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // flags = {frame_done, err_early_eol, err_late_eol, err_sof_mid}
    task automatic chk_rec(input string nm, input int k, input int ex, input int ey,
                           input logic [7:0] ed, input logic [3:0] flags);
        rec_t r;
        if (k >= q.size()) begin
            chk($sformatf("%s[%0d].present", nm, k), q.size(), k + 1);
            return;
        end
        r = q[k];
        chk($sformatf("%s[%0d].x", nm, k), 32'(r.x), ex);
        chk($sformatf("%s[%0d].y", nm, k), 32'(r.y), ey);
        chk($sformatf("%s[%0d].data", nm, k), 32'(r.d), 32'(ed));
        chk($sformatf("%s[%0d].flags", nm, k), 32'({r.fd, r.ee, r.el, r.sm}), 32'(flags));
    endtask

    task automatic send_clean(input logic [7:0] base);
        for (int i = 0; i < 100; i++) begin
            beat(8'(base + i), i == 0, (i % 10) == 9);
        end
    endtask

    // Records start..start+99 form a clean 10x10 frame of data base+i.
    task automatic chk_clean(input string nm, input int start, input logic [7:0] base);
        chk({nm, ".count"}, q.size(), start + 100);
        for (int i = 0; i < 100; i++) begin
            chk_rec(nm, start + i, i % 10, i / 10, 8'(base + i), {(i == 99), 3'b000});
        end
    endtask

    initial begin
        sys_rst        = 1'b1;
        s_video_tdata  = '0;
        s_video_tvalid = 1'b0;
        s_video_tlast  = 1'b0;
        s_video_tuser  = 1'b0;
        idle(3);

        // Reset state
        chk("rst.pix_valid", 32'(pix_valid), 0);
        chk("rst.pix_data", 32'(pix_data), 0);
        chk("rst.pix_x", 32'(pix_x), 0);
        chk("rst.pix_y", 32'(pix_y), 0);
        chk("rst.pulses", 32'({frame_done, err_early_eol, err_late_eol, err_sof_mid}), 0);
        chk("rst.frame_cnt", 32'(frame_cnt), 0);
`ifdef VIDEO_RX_GAP_STAT_EN
        chk("rst.gap_cnt", 32'(gap_cnt), 0);
`endif
        sys_rst = 1'b0;
        idle(1);

        // 20 beats before any tuser are discarded
        for (int i = 0; i < 20; i++) beat(8'(8'hA0 + i), 1'b0, (i % 10) == 9);
        idle(2);
        chk("presof.count", q.size(), 0);

        // Clean frame, continuous tvalid
        q.delete();
        send_clean(8'h10);
        idle(2);
        chk_clean("clean", 0, 8'h10);
        chk("clean.frame_cnt", 32'(frame_cnt), 1);
`ifdef VIDEO_RX_GAP_STAT_EN
        chk("clean.gap_cnt", 32'(gap_cnt), 0);
`endif

        // Same frame with 4-cycle gaps before pixels 2, 7, 25, 98
        q.delete();
        for (int i = 0; i < 100; i++) begin
            if (i == 2 || i == 7 || i == 25 || i == 98) idle(4);
            beat(8'(8'h40 + i), i == 0, (i % 10) == 9);
        end
        idle(2);
        chk_clean("gaps", 0, 8'h40);
        chk("gaps.frame_cnt", 32'(frame_cnt), 2);
`ifdef VIDEO_RX_GAP_STAT_EN
        chk("gaps.gap_cnt", 32'(gap_cnt), 16);
`endif

        // Early tlast at column 5 of line 3: 96 beats total
        q.delete();
        for (int k = 0; k < 96; k++) begin
            if (k < 36) beat(8'(k), k == 0, ((k % 10) == 9) || k == 35);
            else beat(8'(k), 1'b0, ((k - 36) % 10) == 9);
        end
        idle(2);
        chk("early.count", q.size(), 96);
        chk_rec("early", 34, 4, 3, 8'(34), 4'b0000);
        chk_rec("early", 35, 5, 3, 8'(35), 4'b0100);
        chk_rec("early", 36, 0, 4, 8'(36), 4'b0000);
        chk_rec("early", 94, 8, 9, 8'(94), 4'b0000);
        chk_rec("early", 95, 9, 9, 8'(95), 4'b1000);
        chk("early.frame_cnt", 32'(frame_cnt), 3);

        // Missing tlast on line 0: forced close at column 9
        q.delete();
        for (int i = 0; i < 100; i++) beat(8'(8'h80 + i), i == 0, ((i % 10) == 9) && i != 9);
        idle(2);
        chk("late.count", q.size(), 100);
        chk_rec("late", 9, 9, 0, 8'(8'h89), 4'b0010);
        chk_rec("late", 10, 0, 1, 8'(8'h8A), 4'b0000);
        chk_rec("late", 99, 9, 9, 8'(8'h80 + 99), 4'b1000);
        chk("late.frame_cnt", 32'(frame_cnt), 4);

        // tuser (with tlast) at (4,6): restart at (0,0), tlast ignored
        q.delete();
        for (int i = 0; i < 64; i++) beat(8'(i), i == 0, (i % 10) == 9);
        beat(8'hEE, 1'b1, 1'b1);
        idle(1);
        chk("sofmid.frame_cnt_hold", 32'(frame_cnt), 4);
        for (int j = 1; j < 100; j++) beat(8'(8'hC0 + j), 1'b0, (j % 10) == 9);
        idle(2);
        chk("sofmid.count", q.size(), 164);
        chk_rec("sofmid", 63, 3, 6, 8'(63), 4'b0000);
        chk_rec("sofmid", 64, 0, 0, 8'hEE, 4'b0001);
        chk_rec("sofmid", 65, 1, 0, 8'hC1, 4'b0000);
        chk_rec("sofmid", 74, 0, 1, 8'(8'hC0 + 10), 4'b0000);
        chk_rec("sofmid", 163, 9, 9, 8'(8'hC0 + 99), 4'b1000);
        chk("sofmid.frame_cnt", 32'(frame_cnt), 5);

        // Reset asserted on the beat at (3,3)
        for (int i = 0; i < 33; i++) beat(8'(i), i == 0, (i % 10) == 9);
        sys_rst = 1'b1;
        beat(8'(33), 1'b0, 1'b0);
        chk("midrst.pix_valid", 32'(pix_valid), 0);
        chk("midrst.pix_data", 32'(pix_data), 0);
        chk("midrst.pix_xy", 32'({pix_x, pix_y}), 0);
        chk("midrst.frame_cnt", 32'(frame_cnt), 0);
        sys_rst = 1'b0;
        q.delete();
        for (int i = 34; i < 100; i++) beat(8'(i), 1'b0, (i % 10) == 9);
        idle(2);
        chk("midrst.ignored", q.size(), 0);
        send_clean(8'h55);
        idle(2);
        chk_clean("resync", 0, 8'h55);
        chk("resync.frame_cnt", 32'(frame_cnt), 1);

        chk("stray_pulses", stray, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
